// File: rtl/ahb_uart_pkg.sv
// Shared definitions for the AHB-Lite UART: register offsets (HADDR[3:2]),
// STATUS bit positions and the serial FSM state encoding used by TX and RX.
package ahb_uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_BAUD   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int STAT_TX_FULL    = 0;
    localparam int STAT_TX_EMPTY   = 1;
    localparam int STAT_RX_VALID   = 2;
    localparam int STAT_RX_OVERRUN = 3;
    localparam int STAT_TX_BUSY    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead synchronous FIFO; DEPTH must be a power of two so the pointers
// wrap naturally. A push while full is taken only alongside a pop.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ahblite_uart.sv
// AHB-Lite 8N1 UART with TX/RX FIFOs and programmable divisor.
// Define AHB_UART_IRQ_EN to implement the CTRL register and the IRQ output.
module ahblite_uart
    import ahb_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RESET = 16'd433
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        TXD,
    input  logic        RXD,
    output logic        IRQ
);

    logic        acc_reg;
    logic        wr_reg;
    logic [1:0]  addr_reg;
    logic [15:0] baud_reg;
    logic        overrun_reg;

    logic        data_wr, data_rd, status_wr, baud_wr;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_dout;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_dout;
    logic [31:0] ctrl_rd;
    logic [31:0] rdata;

    logic unused_bits;
    assign unused_bits = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Address phase captured here; the data phase acts on these registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            acc_reg  <= 1'b0;
            wr_reg   <= 1'b0;
            addr_reg <= 2'd0;
        end else begin
            acc_reg  <= HSEL & HTRANS[1] & HREADY;
            wr_reg   <= HWRITE;
            addr_reg <= HADDR[3:2];
        end
    end

    assign data_wr   = acc_reg &&  wr_reg && (addr_reg == ADDR_DATA);
    assign data_rd   = acc_reg && !wr_reg && (addr_reg == ADDR_DATA);
    assign status_wr = acc_reg &&  wr_reg && (addr_reg == ADDR_STATUS);
    assign baud_wr   = acc_reg &&  wr_reg && (addr_reg == ADDR_BAUD);

    assign tx_push = data_wr;
    assign rx_pop  = data_rd && !rx_empty;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            baud_reg    <= BAUD_RESET;
            overrun_reg <= 1'b0;
        end else begin
            if (baud_wr) begin
                baud_reg <= HWDATA[15:0];
            end
            // A new overrun wins over a simultaneous clear.
            if (rx_push && rx_full && !rx_pop) begin
                overrun_reg <= 1'b1;
            end else if (status_wr && HWDATA[STAT_RX_OVERRUN]) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (HCLK),
        .srst  (HRESET),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (HWDATA[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // ---------------- transmitter ----------------
    uart_state_t tx_state_reg;
    logic [15:0] tx_cnt_reg;
    logic [2:0]  tx_bit_reg;
    logic [7:0]  tx_shift_reg;
    logic        txd_reg;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt_reg >= baud_reg);
    // Popping straight out of STOP keeps consecutive frames gap-free.
    assign tx_pop = !tx_empty &&
                    ((tx_state_reg == ST_IDLE) || ((tx_state_reg == ST_STOP) && tx_bit_end));
    assign TXD = txd_reg;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tx_state_reg <= ST_IDLE;
            tx_cnt_reg   <= 16'd0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'd0;
            txd_reg      <= 1'b1;
        end else begin
            case (tx_state_reg)
                ST_IDLE: begin
                    tx_cnt_reg <= 16'd0;
                    txd_reg    <= 1'b1;
                    if (tx_pop) begin
                        tx_shift_reg <= tx_dout;
                        txd_reg      <= 1'b0;
                        tx_state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_cnt_reg   <= 16'd0;
                        tx_bit_reg   <= 3'd0;
                        txd_reg      <= tx_shift_reg[0];
                        tx_state_reg <= ST_DATA;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt_reg <= 16'd0;
                        if (tx_bit_reg == 3'd7) begin
                            txd_reg      <= 1'b1;
                            tx_state_reg <= ST_STOP;
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                            txd_reg      <= tx_shift_reg[1];
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt_reg <= 16'd0;
                        if (tx_pop) begin
                            tx_shift_reg <= tx_dout;
                            txd_reg      <= 1'b0;
                            tx_state_reg <= ST_START;
                        end else begin
                            tx_state_reg <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 16'd1;
                    end
                end
                default: tx_state_reg <= ST_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    uart_state_t rx_state_reg;
    logic [15:0] rx_cnt_reg;
    logic [2:0]  rx_bit_reg;
    logic [7:0]  rx_shift_reg;
    logic        rx_sync1_reg, rx_sync2_reg, rx_sync3_reg;
    logic        rx_bit_end;
    logic [16:0] rx_half;

    assign rx_bit_end = (rx_cnt_reg >= baud_reg);
    assign rx_half    = ({1'b0, baud_reg} + 17'd1) >> 1;
    assign rx_push    = (rx_state_reg == ST_STOP) && rx_bit_end && rx_sync2_reg;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
            rx_sync3_reg <= 1'b1;
            rx_state_reg <= ST_IDLE;
            rx_cnt_reg   <= 16'd0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'd0;
        end else begin
            rx_sync1_reg <= RXD;
            rx_sync2_reg <= rx_sync1_reg;
            rx_sync3_reg <= rx_sync2_reg;
            case (rx_state_reg)
                ST_IDLE: begin
                    rx_cnt_reg <= 16'd0;
                    if (rx_sync3_reg && !rx_sync2_reg) begin
                        rx_state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    // Re-check the line half a bit in to reject glitches.
                    if (({1'b0, rx_cnt_reg} + 17'd1) >= rx_half) begin
                        rx_cnt_reg   <= 16'd0;
                        rx_bit_reg   <= 3'd0;
                        rx_state_reg <= rx_sync2_reg ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt_reg   <= 16'd0;
                        rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7) begin
                            rx_state_reg <= ST_STOP;
                        end else begin
                            rx_bit_reg <= rx_bit_reg + 3'd1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt_reg   <= 16'd0;
                        rx_state_reg <= ST_IDLE;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 16'd1;
                    end
                end
                default: rx_state_reg <= ST_IDLE;
            endcase
        end
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (HCLK),
        .srst  (HRESET),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_shift_reg),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // ---------------- interrupt ----------------
`ifdef AHB_UART_IRQ_EN
    logic [1:0] ctrl_reg;
    logic       irq_reg;
    logic       ctrl_wr;

    assign ctrl_wr = acc_reg && wr_reg && (addr_reg == ADDR_CTRL);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_reg <= 2'd0;
            irq_reg  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_reg <= HWDATA[1:0];
            end
            irq_reg <= (ctrl_reg[0] & (!rx_empty | overrun_reg)) | (ctrl_reg[1] & tx_empty);
        end
    end

    assign ctrl_rd = {30'd0, ctrl_reg};
    assign IRQ     = irq_reg;
`else
    assign ctrl_rd = 32'd0;
    assign IRQ     = 1'b0;
`endif

    always_comb begin
        rdata = 32'd0;
        case (addr_reg)
            ADDR_DATA: begin
                if (!rx_empty) begin
                    rdata[7:0] = rx_dout;
                end
            end
            ADDR_STATUS: begin
                rdata[STAT_TX_FULL]    = tx_full;
                rdata[STAT_TX_EMPTY]   = tx_empty;
                rdata[STAT_RX_VALID]   = !rx_empty;
                rdata[STAT_RX_OVERRUN] = overrun_reg;
                rdata[STAT_TX_BUSY]    = (tx_state_reg != ST_IDLE);
            end
            ADDR_BAUD: rdata[15:0] = baud_reg;
            default:   rdata = ctrl_rd;
        endcase
    end

    assign HRDATA = (acc_reg && !wr_reg) ? rdata : 32'd0;

endmodule
